// File: rtl/tlb_pkg.sv
// Shared types, constants and compare helpers for the LoongArch TLB CAM.
package tlb_pkg;

  localparam int VPPN_W = 19;
  localparam int ASID_W = 10;
  localparam int PPN_W  = 20;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  // INVTLB op codes
  localparam logic [4:0] INV_ALL0         = 5'd0;
  localparam logic [4:0] INV_ALL1         = 5'd1;
  localparam logic [4:0] INV_GLB          = 5'd2;
  localparam logic [4:0] INV_NGLB         = 5'd3;
  localparam logic [4:0] INV_NGLB_ASID    = 5'd4;
  localparam logic [4:0] INV_NGLB_ASID_VA = 5'd5;
  localparam logic [4:0] INV_ASID_VA      = 5'd6;

  // Entry payload. The E bit lives in its own vector so that reset can
  // clear it without touching the rest of the entry.
  typedef struct packed {
    logic [VPPN_W-1:0] vppn;
    logic [5:0]        ps;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PPN_W-1:0]  ppn0;
    logic [1:0]        plv0;
    logic [1:0]        mat0;
    logic              d0;
    logic              v0;
    logic [PPN_W-1:0]  ppn1;
    logic [1:0]        plv1;
    logic [1:0]        mat1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  // Lookup result for one port (index carried separately, it is parametric).
  typedef struct packed {
    logic              found;
    logic              multi;
    logic [PPN_W-1:0]  ppn;
    logic [5:0]        ps;
    logic [1:0]        plv;
    logic [1:0]        mat;
    logic              d;
    logic              v;
  } tlb_hit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INV,
    ST_DONE
  } inv_state_t;

  // 4M pages compare only the upper VPPN bits; everything else compares all.
  function automatic logic vppn_hit(input logic [5:0]        ps,
                                    input logic [VPPN_W-1:0] ent_vppn,
                                    input logic [VPPN_W-1:0] key_vppn);
    if (ps == PS_4M) return ent_vppn[18:9] == key_vppn[18:9];
    return ent_vppn == key_vppn;
  endfunction

  // Whether INVTLB op clears an entry with the given attributes.
  function automatic logic inv_kill(input logic [4:0] op,
                                    input logic       g,
                                    input logic       asid_eq,
                                    input logic       va_eq);
    case (op)
      INV_ALL0, INV_ALL1: return 1'b1;
      INV_GLB:            return g;
      INV_NGLB:           return ~g;
      INV_NGLB_ASID:      return ~g & asid_eq;
      INV_NGLB_ASID_VA:   return ~g & asid_eq & va_eq;
      INV_ASID_VA:        return (g | asid_eq) & va_eq;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational single-port TLB search: match vector, lowest-index priority
// encode, multi-hit flag and page-half selection. Miss returns all zeros.
module tlb_match
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic [TLBNUM-1:0]       ent_e,
  input  tlb_entry_t [TLBNUM-1:0] ent,
  input  logic [VPPN_W-1:0]       key_vppn,
  input  logic                    key_bit12,
  input  logic [ASID_W-1:0]       key_asid,
  output tlb_hit_t                hit,
  output logic [IDXW-1:0]         index
);

  logic [TLBNUM-1:0] match;
  tlb_entry_t        sel;
  logic              odd;

  genvar gi;
  for (gi = 0; gi < TLBNUM; gi++) begin : g_cmp
    assign match[gi] = ent_e[gi]
                     & (ent[gi].g | (ent[gi].asid == key_asid))
                     & vppn_hit(ent[gi].ps, ent[gi].vppn, key_vppn);
  end

  // Priority encoder: scanning downward leaves the lowest matching index.
  always_comb begin
    index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) index = IDXW'(i);
    end
  end

  // Pick the even/odd half of the winning entry; zero everything on a miss.
  always_comb begin
    sel = ent[index];
    odd = (sel.ps == PS_4K) ? key_bit12 : key_vppn[8];
    hit = '0;
    if (|match) begin
      hit.found = 1'b1;
      hit.multi = |(match & (match - TLBNUM'(1)));
      hit.ps    = sel.ps;
      if (odd) begin
        hit.ppn = sel.ppn1;
        hit.plv = sel.plv1;
        hit.mat = sel.mat1;
        hit.d   = sel.d1;
        hit.v   = sel.v1;
      end else begin
        hit.ppn = sel.ppn0;
        hit.plv = sel.plv0;
        hit.mat = sel.mat0;
        hit.d   = sel.d0;
        hit.v   = sel.v0;
      end
    end
  end

endmodule

// File: rtl/tlb_cam_mp.sv
// Multi-port fully-associative LoongArch TLB with registered lookups,
// registered entry read, INVTLB state machine and TLBFILL victim counter.
// Optional per-port hit/miss counters are built when TLB_PERF_EN is defined.
module tlb_cam_mp
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  parameter  int NPORT  = 2,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  // search ports
  input  logic [NPORT-1:0]        s_req,
  input  logic [NPORT*VPPN_W-1:0] s_vppn,
  input  logic [NPORT-1:0]        s_va_bit12,
  input  logic [NPORT*ASID_W-1:0] s_asid,
  output logic [NPORT-1:0]        s_rsp_valid,
  output logic [NPORT-1:0]        s_found,
  output logic [NPORT-1:0]        s_multi,
  output logic [NPORT*IDXW-1:0]   s_index,
  output logic [NPORT*PPN_W-1:0]  s_ppn,
  output logic [NPORT*6-1:0]      s_ps,
  output logic [NPORT*2-1:0]      s_plv,
  output logic [NPORT*2-1:0]      s_mat,
  output logic [NPORT-1:0]        s_d,
  output logic [NPORT-1:0]        s_v,
  // write port
  input  logic                    we,
  input  logic [IDXW-1:0]         w_index,
  input  logic                    w_e,
  input  logic [VPPN_W-1:0]       w_vppn,
  input  logic [5:0]              w_ps,
  input  logic [ASID_W-1:0]       w_asid,
  input  logic                    w_g,
  input  logic [PPN_W-1:0]        w_ppn0,
  input  logic [1:0]              w_plv0,
  input  logic [1:0]              w_mat0,
  input  logic                    w_d0,
  input  logic                    w_v0,
  input  logic [PPN_W-1:0]        w_ppn1,
  input  logic [1:0]              w_plv1,
  input  logic [1:0]              w_mat1,
  input  logic                    w_d1,
  input  logic                    w_v1,
  // read port
  input  logic [IDXW-1:0]         r_index,
  output logic                    r_e,
  output logic [VPPN_W-1:0]       r_vppn,
  output logic [5:0]              r_ps,
  output logic [ASID_W-1:0]       r_asid,
  output logic                    r_g,
  output logic [PPN_W-1:0]        r_ppn0,
  output logic [1:0]              r_plv0,
  output logic [1:0]              r_mat0,
  output logic                    r_d0,
  output logic                    r_v0,
  output logic [PPN_W-1:0]        r_ppn1,
  output logic [1:0]              r_plv1,
  output logic [1:0]              r_mat1,
  output logic                    r_d1,
  output logic                    r_v1,
  // INVTLB
  input  logic                    inv_valid,
  input  logic [4:0]              inv_op,
  input  logic [ASID_W-1:0]       inv_asid,
  input  logic [VPPN_W-1:0]       inv_vppn,
  output logic                    inv_ready,
  output logic                    inv_done,
  output logic                    inv_ill,
`ifdef TLB_PERF_EN
  output logic [NPORT*32-1:0]     perf_hit,
  output logic [NPORT*32-1:0]     perf_miss,
`endif
  output logic [IDXW-1:0]         fill_index
);

  tlb_entry_t [TLBNUM-1:0] ent_q;
  logic [TLBNUM-1:0]       e_q, e_d;
  logic [TLBNUM-1:0]       kill;
  tlb_entry_t              w_ent;

  inv_state_t              state_q;
  logic [4:0]              inv_op_q;
  logic [ASID_W-1:0]       inv_asid_q;
  logic [VPPN_W-1:0]       inv_vppn_q;
  logic                    inv_done_q, inv_ill_q;

  logic [IDXW-1:0]         fill_q, fill_d;
  logic                    rd_e_q, rd_e_d;
  tlb_entry_t              rd_q, rd_d;

  assign w_ent = '{vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                   ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0, d0: w_d0, v0: w_v0,
                   ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1, d1: w_d1, v1: w_v1};

  // Entry payload storage; only E is reset, the rest holds its last write.
  always_ff @(posedge clk) begin
    if (we) ent_q[w_index] <= w_ent;
  end

  genvar gi;
  for (gi = 0; gi < TLBNUM; gi++) begin : g_kill
    assign kill[gi] = inv_kill(inv_op_q, ent_q[gi].g,
                               ent_q[gi].asid == inv_asid_q,
                               vppn_hit(ent_q[gi].ps, ent_q[gi].vppn, inv_vppn_q));
  end

  // Next valid bits: invalidation in the INV cycle, a same-cycle write wins for its index.
  always_comb begin
    e_d = e_q;
    if (state_q == ST_INV) e_d = e_q & ~kill;
    if (we) e_d[w_index] = w_e;
  end

  // Valid-bit register.
  always_ff @(posedge clk) begin
    if (reset) e_q <= '0;
    else       e_q <= e_d;
  end

  // A pending write blocks the INVTLB handshake.
  assign inv_ready = (state_q == ST_IDLE) & inv_valid & ~we;

  // INVTLB sequencer: IDLE -> INV (clear) -> DONE (pulse) -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      inv_done_q <= 1'b0;
      inv_ill_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          inv_done_q <= 1'b0;
          inv_ill_q  <= 1'b0;
          if (inv_ready) begin
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vppn_q <= inv_vppn;
            state_q    <= ST_INV;
          end
        end
        ST_INV: begin
          inv_done_q <= 1'b1;
          inv_ill_q  <= inv_op_q > INV_ASID_VA;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          inv_done_q <= 1'b0;
          inv_ill_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign inv_done = inv_done_q;
  assign inv_ill  = inv_ill_q;

  // Read port and free-running fill counter (wraps naturally at TLBNUM).
  always_comb begin
    rd_e_d = e_q[r_index];
    rd_d   = rd_e_d ? ent_q[r_index] : '0;
    fill_d = fill_q + IDXW'(1);
  end

  // Read-port and fill-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_e_q <= 1'b0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      rd_e_q <= rd_e_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
    end
  end

  assign fill_index = fill_q;
  assign r_e    = rd_e_q;
  assign r_vppn = rd_q.vppn;
  assign r_ps   = rd_q.ps;
  assign r_asid = rd_q.asid;
  assign r_g    = rd_q.g;
  assign r_ppn0 = rd_q.ppn0;
  assign r_plv0 = rd_q.plv0;
  assign r_mat0 = rd_q.mat0;
  assign r_d0   = rd_q.d0;
  assign r_v0   = rd_q.v0;
  assign r_ppn1 = rd_q.ppn1;
  assign r_plv1 = rd_q.plv1;
  assign r_mat1 = rd_q.mat1;
  assign r_d1   = rd_q.d1;
  assign r_v1   = rd_q.v1;

  for (gi = 0; gi < NPORT; gi++) begin : g_port
    tlb_hit_t        hit_c, hit_d, hit_q;
    logic [IDXW-1:0] index_c, index_d, index_q;
    logic            rsp_valid_d, rsp_valid_q;

    tlb_match #(.TLBNUM(TLBNUM)) u_match (
      .ent_e    (e_q),
      .ent      (ent_q),
      .key_vppn (s_vppn[gi*VPPN_W +: VPPN_W]),
      .key_bit12(s_va_bit12[gi]),
      .key_asid (s_asid[gi*ASID_W +: ASID_W]),
      .hit      (hit_c),
      .index    (index_c)
    );

    // Capture a new result on request, otherwise hold the previous one.
    always_comb begin
      rsp_valid_d = s_req[gi];
      hit_d       = hit_q;
      index_d     = index_q;
      if (s_req[gi]) begin
        hit_d   = hit_c;
        index_d = index_c;
      end
    end

    // Lookup result registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        rsp_valid_q <= 1'b0;
        hit_q       <= '0;
        index_q     <= '0;
      end else begin
        rsp_valid_q <= rsp_valid_d;
        hit_q       <= hit_d;
        index_q     <= index_d;
      end
    end

    assign s_rsp_valid[gi]           = rsp_valid_q;
    assign s_found[gi]               = hit_q.found;
    assign s_multi[gi]               = hit_q.multi;
    assign s_index[gi*IDXW +: IDXW]  = index_q;
    assign s_ppn[gi*PPN_W +: PPN_W]  = hit_q.ppn;
    assign s_ps[gi*6 +: 6]           = hit_q.ps;
    assign s_plv[gi*2 +: 2]          = hit_q.plv;
    assign s_mat[gi*2 +: 2]          = hit_q.mat;
    assign s_d[gi]                   = hit_q.d;
    assign s_v[gi]                   = hit_q.v;

`ifdef TLB_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Count every presented response as a hit or a miss.
    always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (rsp_valid_q &  hit_q.found) hit_cnt_d  = hit_cnt_q + 32'd1;
      if (rsp_valid_q & ~hit_q.found) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else begin
        hit_cnt_q  <= hit_cnt_d;
        miss_cnt_q <= miss_cnt_d;
      end
    end

    assign perf_hit[gi*32 +: 32]  = hit_cnt_q;
    assign perf_miss[gi*32 +: 32] = miss_cnt_q;
`endif
  end

endmodule
